conv_stream_feeder: RTL
=======================

CONV_STREAM_FEEDER -- requirements
Module: conv_stream_feeder

Interface
REQ-001 The block SHALL have parameter IFM_WIDTH, default 8, meaning input-feature-map pixel width.
REQ-002 The block SHALL have parameter WEIGHT_WIDTH, default 8, meaning kernel weight width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 16, meaning CONV output word width.
REQ-004 The block SHALL have parameters IFM_SIZE 64, KERNEL_SIZE 3, PAD 0, STRIDE 1, CI 3 and CO 8, meaning the convolution geometry served.
REQ-005 The block SHALL have derived constants IFM_DEPTH=CI*IFM_SIZE^2, WGT_DEPTH=CO*CI*KERNEL_SIZE^2, OFM_SIZE=(IFM_SIZE+2*PAD-KERNEL_SIZE)/STRIDE+1 and OFM_DEPTH=OFM_SIZE^2*CO.
REQ-006 The block SHALL have clk2, input, 1 bit: the clock.
REQ-007 The block SHALL have rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have start_conv, input, 1 bit: start-of-layer pulse.
REQ-009 The block SHALL have ifm_read and wgt_read, inputs, 1 bit each: CONV fetch requests.
REQ-010 The block SHALL have ifm (IFM_WIDTH) and wgt (WEIGHT_WIDTH), outputs, with ifm_valid and wgt_valid, outputs, 1 bit each: fetched data and qualifiers.
REQ-011 The block SHALL have out_valid (1), data_output (DATA_WIDTH) and end_conv (1), inputs: CONV result stream.
REQ-012 The block SHALL have ld_en (1), ld_sel (2; 0=IFM, 1=WGT, 2=GOLDEN), ld_addr (32) and ld_data (DATA_WIDTH), inputs: backdoor memory load.
REQ-013 The block SHALL have done (1), pass (1), err_count (32) and first_err_idx (32), outputs: check status.

Function
REQ-014 Three internal memories (IFM_DEPTH x IFM_WIDTH, WGT_DEPTH x WEIGHT_WIDTH, OFM_DEPTH x DATA_WIDTH) SHALL be written on clk2 when ld_en=1, using the low bits of ld_data, with out-of-range ld_addr ignored.
REQ-015 An ifm_read in cycle N SHALL present mem[ifm_ptr] on ifm with ifm_valid=1 in cycle N+1 and increment ifm_ptr; with no read, ifm=0 and ifm_valid=0.
REQ-016 ifm_ptr SHALL wrap from IFM_DEPTH-1 to 0, and wgt_ptr SHALL wrap from WGT_DEPTH-1 to 0.
REQ-017 The weight path SHALL behave identically to REQ-015 using wgt_read, wgt_ptr and wgt.
REQ-018 start_conv SHALL clear ifm_ptr, wgt_ptr, ofm_ptr, err_count, first_err_idx, done and pass, and SHALL enter RUN.
REQ-019 When start_conv and a read are in the same cycle, the block SHALL serve address 0 and leave the pointer at 1.
REQ-020 The FSM SHALL have states IDLE, RUN, CHECK and DONE: IDLE->RUN on start_conv; RUN->CHECK on end_conv or when ofm_ptr reaches OFM_DEPTH; CHECK->DONE after one cycle; DONE->RUN on start_conv.
REQ-021 In RUN, each out_valid SHALL capture data_output at ofm_ptr and increment ofm_ptr.
REQ-022 Once ofm_ptr reaches OFM_DEPTH, further out_valid SHALL be ignored.
REQ-023 In CHECK, pass SHALL be set to (err_count==0 && ofm_ptr==OFM_DEPTH).
REQ-024 In DONE, done SHALL be held at 1 until the next start_conv.
REQ-025 out_valid in IDLE or DONE SHALL be ignored.
REQ-026 err_count SHALL saturate at 2^32-1.

Reset
REQ-027 The reset SHALL be asynchronous: rst_n low SHALL force state IDLE, all pointers 0, ifm=0, wgt=0, ifm_valid=0, wgt_valid=0, done=0, pass=0, err_count=0 and first_err_idx=all-ones.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset asserted mid-RUN SHALL abandon the layer, and no done pulse SHALL follow.

Configuration
REQ-030 With macro FEEDER_GOLDEN_CHECK_EN defined, each captured word SHALL be compared with golden[ofm_ptr]; a mismatch SHALL increment err_count, and the first mismatch SHALL record its index in first_err_idx.
REQ-031 Without FEEDER_GOLDEN_CHECK_EN, the golden memory and comparator SHALL be absent, err_count SHALL be tied to 0, first_err_idx SHALL be tied to all-ones, and pass SHALL reflect only the output count.

Structure
REQ-032 Package conv_feeder_pkg SHALL hold the FSM state enum, the ld_sel encodings and the derived-depth functions.
REQ-033 A single sub-module, feeder_rd_port, parametrised by width and depth, SHALL implement the memory, pointer, wrap and valid logic, and SHALL be instantiated for the IFM and WGT paths.

Verification
REQ-034 Load IFM[i]=i mod 256 and pulse start_conv; 3 consecutive ifm_read cycles -> ifm = 0, 1, 2 with ifm_valid=1 on the following cycles.
REQ-035 Issue WGT_DEPTH+1 = 217 wgt_read cycles -> the 217th returns wgt[0] (wrap).
REQ-036 Assert start_conv together with ifm_read at ifm_ptr=100 -> ifm=mem[0] and ifm_ptr=1.
REQ-037 Stream OFM_DEPTH = 30752 outputs equal to the golden data -> done=1 and pass=1 one cycle after CHECK, with err_count=0.
REQ-038 Corrupt outputs 5 and 9 -> err_count=2, first_err_idx=5 and pass=0.
REQ-039 Pull rst_n low mid-RUN, then pulse start_conv again -> ifm_ptr=0, done=0, and a clean second run passes.

Source files
------------

// File: rtl/conv_feeder_pkg.sv
// Shared types and geometry helpers for the convolution stream feeder.
// Holds the FSM state enum, backdoor-load select encodings and depth functions.
package conv_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

  typedef enum logic [1:0] {
    LD_IFM    = 2'd0,
    LD_WGT    = 2'd1,
    LD_GOLDEN = 2'd2
  } ld_sel_e;

  function automatic int ifm_depth(input int ci, input int ifm_size);
    return ci * ifm_size * ifm_size;
  endfunction

  function automatic int wgt_depth(input int co, input int ci, input int kernel_size);
    return co * ci * kernel_size * kernel_size;
  endfunction

  function automatic int ofm_size(input int ifm_size, input int kernel_size,
                                  input int pad, input int stride);
    return (ifm_size + 2 * pad - kernel_size) / stride + 1;
  endfunction

  function automatic int ofm_depth(input int ofm_sz, input int co);
    return ofm_sz * ofm_sz * co;
  endfunction

  // Address width able to index a memory of the given depth (never zero).
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/feeder_rd_port.sv
// Backdoor-loaded memory with an auto-incrementing, wrapping read pointer.
// One registered read per request; output word and valid are zero when idle.
module feeder_rd_port
  import conv_feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk2,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] data,
  output logic             vld
);

  localparam int AW = ptr_w(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;

  // Contents survive reset; only in-range addresses are written.
  always_ff @(posedge clk2) begin
    if (wr && (wr_addr < 32'(DEPTH))) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // A clear coinciding with a read serves address 0 and leaves the pointer at 1.
  assign rd_addr = clr ? '0 : ptr;

  // Stage p1: registered read data and qualifier
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd;
      if (rd) begin
        data_p1 <= mem[rd_addr];
        ptr     <= (rd_addr == LAST) ? '0 : rd_addr + AW'(1);
      end else begin
        data_p1 <= '0;
        if (clr) begin
          ptr <= '0;
        end
      end
    end
  end

  assign data = data_p1;
  assign vld  = vld_p1;

endmodule

// File: rtl/conv_stream_feeder.sv
// Feeds IFM/weight words to a CONV engine and collects its output stream.
// Define FEEDER_GOLDEN_CHECK_EN to build the golden memory and mismatch counter.
module conv_stream_feeder
  import conv_feeder_pkg::*;
#(
  parameter int IFM_WIDTH    = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int IFM_SIZE     = 64,
  parameter int KERNEL_SIZE  = 3,
  parameter int PAD          = 0,
  parameter int STRIDE       = 1,
  parameter int CI           = 3,
  parameter int CO           = 8
) (
  input  logic                    clk2,
  input  logic                    rst_n,
  input  logic                    start_conv,
  input  logic                    ifm_read,
  input  logic                    wgt_read,
  output logic [IFM_WIDTH-1:0]    ifm,
  output logic [WEIGHT_WIDTH-1:0] wgt,
  output logic                    ifm_valid,
  output logic                    wgt_valid,
  input  logic                    out_valid,
  input  logic [DATA_WIDTH-1:0]   data_output,
  input  logic                    end_conv,
  input  logic                    ld_en,
  input  logic [1:0]              ld_sel,
  input  logic [31:0]             ld_addr,
  input  logic [DATA_WIDTH-1:0]   ld_data,
  output logic                    done,
  output logic                    pass,
  output logic [31:0]             err_count,
  output logic [31:0]             first_err_idx
);

  localparam int IFM_DEPTH = ifm_depth(CI, IFM_SIZE);
  localparam int WGT_DEPTH = wgt_depth(CO, CI, KERNEL_SIZE);
  localparam int OFM_SIZE  = ofm_size(IFM_SIZE, KERNEL_SIZE, PAD, STRIDE);
  localparam int OFM_DEPTH = ofm_depth(OFM_SIZE, CO);
  localparam int OW        = $clog2(OFM_DEPTH + 1);
  localparam logic [OW-1:0] OFM_FULL = OW'(OFM_DEPTH);

  feeder_state_e state;
  logic [OW-1:0] ofm_ptr;
  logic          accept;
  logic          mismatch;

  feeder_rd_port #(
    .WIDTH (IFM_WIDTH),
    .DEPTH (IFM_DEPTH)
  ) u_ifm_port (
    .clk2    (clk2),
    .rst_n   (rst_n),
    .clr     (start_conv),
    .rd      (ifm_read),
    .wr      (ld_en && (ld_sel == LD_IFM)),
    .wr_addr (ld_addr),
    .wr_data (ld_data[IFM_WIDTH-1:0]),
    .data    (ifm),
    .vld     (ifm_valid)
  );

  feeder_rd_port #(
    .WIDTH (WEIGHT_WIDTH),
    .DEPTH (WGT_DEPTH)
  ) u_wgt_port (
    .clk2    (clk2),
    .rst_n   (rst_n),
    .clr     (start_conv),
    .rd      (wgt_read),
    .wr      (ld_en && (ld_sel == LD_WGT)),
    .wr_addr (ld_addr),
    .wr_data (ld_data[WEIGHT_WIDTH-1:0]),
    .data    (wgt),
    .vld     (wgt_valid)
  );

  // A start in the same cycle wins over capture: the layer restarts from zero.
  assign accept = (state == ST_RUN) && out_valid && (ofm_ptr != OFM_FULL) && !start_conv;

`ifdef FEEDER_GOLDEN_CHECK_EN
  localparam int GW = ptr_w(OFM_DEPTH);

  logic [DATA_WIDTH-1:0] golden [OFM_DEPTH];

  always_ff @(posedge clk2) begin
    if (ld_en && (ld_sel == LD_GOLDEN) && (ld_addr < 32'(OFM_DEPTH))) begin
      golden[ld_addr[GW-1:0]] <= ld_data;
    end
  end

  assign mismatch = accept && (data_output != golden[ofm_ptr[GW-1:0]]);

  // All-ones in first_err_idx marks a layer with no recorded mismatch.
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      err_count     <= '0;
      first_err_idx <= '1;
    end else if (start_conv) begin
      err_count     <= '0;
      first_err_idx <= '1;
    end else if (mismatch) begin
      if (err_count != '1) begin
        err_count <= err_count + 32'd1;
      end
      if (err_count == '0) begin
        first_err_idx <= 32'(ofm_ptr);
      end
    end
  end
`else
  logic unused_inputs;

  assign mismatch      = 1'b0;
  assign err_count     = '0;
  assign first_err_idx = '1;
  assign unused_inputs = ^{data_output, ld_data, mismatch};
`endif

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ofm_ptr <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else if (start_conv) begin
      state   <= ST_RUN;
      ofm_ptr <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
        end
        ST_RUN: begin
          if (accept) begin
            ofm_ptr <= ofm_ptr + OW'(1);
          end
          if (end_conv || (ofm_ptr == OFM_FULL)) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          pass  <= (err_count == '0) && (ofm_ptr == OFM_FULL);
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
